// File: rtl/alu_exec_unit_if.sv
// Handshake and operand/result bundle between the issue stage and alu_exec_unit.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      ALU_control;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            branch_taken;
    logic            illegal;

    modport master (
        output in_valid, ALU_control, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, branch_taken, illegal
    );

    modport slave (
        input  in_valid, ALU_control, op_a, op_b, out_ready,
        output in_ready, out_valid, result, branch_taken, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake; define ALU_MUL_EN to build the
// iterative shift-add multiplier for code 1 (otherwise code 1 is reported illegal).
//   state  | meaning
//   S_IDLE | accepting operations, single-cycle results load directly
//   S_MUL  | shift-add multiply in progress, one multiplier bit per cycle
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] w_res;
    logic            w_br;
    logic            w_ill;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_is_mul;

    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_br;
    logic            r_ill;

    always_comb begin
        w_res = '0;
        w_br  = 1'b0;
        w_ill = 1'b0;
        case (bus.ALU_control)
            4'd0: w_res = '0;
`ifdef ALU_MUL_EN
            4'd1: w_ill = 1'b0;
`else
            4'd1: w_ill = 1'b1;
`endif
            4'd2: w_res = bus.op_a + bus.op_b;
            4'd3: w_res = bus.op_a << bus.op_b[SHW-1:0];
            4'd4: w_res = bus.op_a ^ bus.op_b;
            4'd5: begin
                w_res = bus.op_a - bus.op_b;
                w_br  = (bus.op_a == bus.op_b);
            end
            4'd6: w_res = bus.op_a - bus.op_b;
            4'd7: begin
                w_res = bus.op_a - bus.op_b;
                w_br  = ($signed(bus.op_a) >= $signed(bus.op_b));
            end
            default: w_ill = 1'b1;
        endcase
    end

    assign w_accept = bus.in_valid && w_in_ready;

`ifdef ALU_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_acc;
    logic [SHW-1:0]  r_count;
    logic [XLEN-1:0] w_acc_next;
    logic            w_mul_done;

    assign w_is_mul   = (bus.ALU_control == 4'd1);
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_mul) w_state_next = S_MUL;
            S_MUL:   if (r_count == '0) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
        w_mul_done = (r_state == S_MUL) && (r_count == '0);
    end

    // r_count is a down-counter; the iteration seen with count==0 is the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand  <= bus.op_a;
            r_mplier <= bus.op_b;
            r_acc    <= '0;
            r_count  <= SHW'(XLEN - 1);
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_count != '0) r_count <= r_count - 1'b1;
        end
    end
`else
    assign w_is_mul   = 1'b0;
    assign w_in_ready = !r_out_valid || bus.out_ready;
`endif

    // A new load takes priority over retiring the current result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_br        <= 1'b0;
            r_ill       <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_br        <= w_br;
            r_ill       <= w_ill;
        end
`ifdef ALU_MUL_EN
        else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_acc_next;
            r_br        <= 1'b0;
            r_ill       <= 1'b0;
        end
`endif
        else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.result       = r_result;
    assign bus.branch_taken = r_br;
    assign bus.illegal      = r_ill;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit; multiply scenarios follow ALU_MUL_EN.
module tb_alu_exec_unit;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic            br;
        logic            ill;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    alu_exec_unit_if #(.XLEN(XLEN)) u_if ();

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] c, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
        exp_t e;
        e = '0;
        case (c)
            4'd0: e.res = '0;
`ifdef ALU_MUL_EN
            4'd1: e.res = a * b;
`else
            4'd1: e.ill = 1'b1;
`endif
            4'd2: e.res = a + b;
            4'd3: e.res = a << b[4:0];
            4'd4: e.res = a ^ b;
            4'd5: begin e.res = a - b; e.br = (a == b); end
            4'd6: e.res = a - b;
            4'd7: begin e.res = a - b; e.br = !($signed(a) < $signed(b)); end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic drive_op(input logic [3:0] c, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input bit push);
        u_if.in_valid    = 1'b1;
        u_if.ALU_control = c;
        u_if.op_a        = a;
        u_if.op_b        = b;
        if (push) exp_q.push_back(model(c, a, b));
    endtask

    task automatic test_reset;
        rst = 1'b1;
        u_if.in_valid = 1'b0;
        u_if.ALU_control = '0;
        u_if.op_a = '0;
        u_if.op_b = '0;
        u_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (u_if.in_ready !== 1'b1 || u_if.out_valid !== 1'b0 || u_if.result !== '0) begin
            errors++;
            $display("FAIL reset_init: in_ready=%b out_valid=%b result=%h want 1 0 0",
                     u_if.in_ready, u_if.out_valid, u_if.result);
        end
        @(negedge clk);
        drive_op(4'd5, 32'd4, 32'd4, 1'b0);
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        checks++;
        if (u_if.out_valid !== 1'b1 || u_if.branch_taken !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: out_valid=%b branch=%b want 1 1",
                     u_if.out_valid, u_if.branch_taken);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (u_if.out_valid !== 1'b0 || u_if.result !== '0 || u_if.branch_taken !== 1'b0
            || u_if.illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out_valid=%b result=%h br=%b ill=%b want all 0",
                     u_if.out_valid, u_if.result, u_if.branch_taken, u_if.illegal);
        end
        @(negedge clk);
        rst = 1'b0;
        u_if.out_ready = 1'b1;
        #1;
        checks++;
        if (u_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b want 1", u_if.in_ready);
        end
    endtask

    // Each entry is accepted on consecutive edges with out_ready held high.
    task automatic test_back_to_back;
        logic [3:0]      codes[6] = '{4'd2, 4'd4, 4'd6, 4'd5, 4'd7, 4'd7};
        logic [XLEN-1:0] as[6]    = '{32'hFFFFFFFF, 32'hF0F0F0F0, 32'd5, 32'd9, 32'hFFFFFFFF, 32'd3};
        logic [XLEN-1:0] bs[6]    = '{32'd1, 32'hFF00FF00, 32'd7, 32'd9, 32'd1, 32'd3};
        logic [XLEN-1:0] want_res[6] = '{32'h0, 32'h0FF00FF0, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFE, 32'h0};
        logic            want_br[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_t e;
        u_if.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_op(codes[i], as[i], bs[i], 1'b1);
            checks++;
            if (u_if.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: in_ready=%b want 1", i, u_if.in_ready);
            end
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.result !== e.res || u_if.branch_taken !== e.br
                || u_if.illegal !== e.ill) begin
                errors++;
                $display("FAIL b2b_result[%0d]: valid=%b result=%h br=%b ill=%b want 1 %h %b %b",
                         i, u_if.out_valid, u_if.result, u_if.branch_taken, u_if.illegal,
                         e.res, e.br, e.ill);
            end
            checks++;
            if (u_if.result !== want_res[i] || u_if.branch_taken !== want_br[i]) begin
                errors++;
                $display("FAIL b2b_table[%0d]: result=%h br=%b want %h %b",
                         i, u_if.result, u_if.branch_taken, want_res[i], want_br[i]);
            end
        end
        @(negedge clk);
        u_if.in_valid = 1'b0;
    endtask

    task automatic test_shift_illegal;
        logic [3:0]      codes[3] = '{4'd3, 4'd9, 4'd0};
        logic [XLEN-1:0] as[3]    = '{32'd1, 32'h1234, 32'h55};
        logic [XLEN-1:0] bs[3]    = '{32'h25, 32'h5678, 32'h66};
        exp_t e;
        u_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_op(codes[i], as[i], bs[i], 1'b1);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.result !== e.res || u_if.illegal !== e.ill
                || u_if.branch_taken !== e.br) begin
                errors++;
                $display("FAIL shift_illegal[%0d]: valid=%b result=%h br=%b ill=%b want 1 %h %b %b",
                         i, u_if.out_valid, u_if.result, u_if.branch_taken, u_if.illegal,
                         e.res, e.br, e.ill);
            end
        end
        checks++;
        if (u_if.illegal !== 1'b0) begin
            errors++;
            $display("FAIL nop_legal: illegal=%b want 0", u_if.illegal);
        end
        @(negedge clk);
        u_if.in_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        exp_t e;
        logic [XLEN-1:0] held;
        @(negedge clk);
        u_if.out_ready = 1'b0;
        drive_op(4'd2, 32'h10, 32'h20, 1'b1);
        @(posedge clk);
        #1;
        held = u_if.result;
        @(negedge clk);
        drive_op(4'd4, 32'hAAAA0000, 32'h0000BBBB, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.result !== held || u_if.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b result=%h in_ready=%b want 1 %h 0",
                         i, u_if.out_valid, u_if.result, u_if.in_ready, held);
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (u_if.result !== e.res) begin
            errors++;
            $display("FAIL bp_value: result=%h want %h", u_if.result, e.res);
        end
        @(negedge clk);
        u_if.out_ready = 1'b1;
        exp_q.push_back(model(4'd4, 32'hAAAA0000, 32'h0000BBBB));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (u_if.out_valid !== 1'b1 || u_if.result !== e.res) begin
            errors++;
            $display("FAIL bp_swap: valid=%b result=%h want 1 %h",
                     u_if.out_valid, u_if.result, e.res);
        end
        @(negedge clk);
        u_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (u_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_retire: out_valid=%b want 0", u_if.out_valid);
        end
    endtask

`ifdef ALU_MUL_EN
    task automatic test_multiply;
        logic [XLEN-1:0] as[2] = '{32'h00012345, 32'hFFFFFFFF};
        logic [XLEN-1:0] bs[2] = '{32'h00000100, 32'hFFFFFFFF};
        logic [XLEN-1:0] want[2] = '{32'h01234500, 32'h00000001};
        exp_t e;
        int   first;
        int   busy_bad;
        int   seen;
        u_if.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive_op(4'd1, as[k], bs[k], 1'b1);
            @(posedge clk);
            #1;
            u_if.in_valid = 1'b0;
            first = -1;
            busy_bad = 0;
            for (int c = 1; c <= 40 && first < 0; c++) begin
                @(posedge clk);
                #1;
                if (u_if.out_valid === 1'b1) first = c;
                else if (u_if.in_ready !== 1'b0) busy_bad++;
            end
            checks++;
            if (first != XLEN || busy_bad != 0) begin
                errors++;
                $display("FAIL mul_latency[%0d]: first_valid=%0d ready_while_busy=%0d want %0d 0",
                         k, first, busy_bad, XLEN);
            end
            e = exp_q.pop_front();
            checks++;
            if (u_if.result !== e.res || u_if.result !== want[k] || u_if.illegal !== 1'b0) begin
                errors++;
                $display("FAIL mul_result[%0d]: result=%h ill=%b want %h 0",
                         k, u_if.result, u_if.illegal, want[k]);
            end
        end
        @(negedge clk);
        drive_op(4'd1, 32'd7, 32'd9, 1'b0);
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (u_if.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || u_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_abort: valid_cycles=%0d in_ready=%b want 0 1", seen, u_if.in_ready);
        end
    endtask
`else
    task automatic test_multiply;
        exp_t e;
        u_if.out_ready = 1'b1;
        @(negedge clk);
        drive_op(4'd1, 32'd3, 32'd4, 1'b1);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (u_if.out_valid !== 1'b1 || u_if.illegal !== 1'b1 || u_if.result !== e.res
            || e.ill !== 1'b1) begin
            errors++;
            $display("FAIL mul_disabled: valid=%b ill=%b result=%h want 1 1 %h",
                     u_if.out_valid, u_if.illegal, u_if.result, e.res);
        end
        @(negedge clk);
        u_if.in_valid = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_back_to_back();
        test_shift_illegal();
        test_backpressure();
        test_multiply();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 4-bit `ALU_control` code from the ALU control decoder plus two operands and produces a result and branch flag. Single-cycle operations complete in one clock. Multiply runs as an iterative shift-add over XLEN cycles. A valid/ready handshake on both sides lets the pipeline stall on multiply or on downstream backpressure.

## Interface
- `XLEN`, default 32, operand/result width (≥ 8).
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operation presented.
- `in_ready` output 1: unit can accept an operation this cycle.
- `ALU_control` input 4: operation code from the decoder.
- `op_a` input XLEN: operand A, i.e. rs1.
- `op_b` input XLEN: operand B, i.e. rs2 or immediate.
- `out_valid` output 1: result register holds a completed operation.
- `out_ready` input 1: downstream consumes the result this cycle.
- `result` output XLEN: operation result.
- `branch_taken` output 1: comparison outcome for branch codes; 0 otherwise.
- `illegal` output 1: code not supported.

## Operation
- Accept happens when `in_valid && in_ready`. Inputs are sampled only at accept.
- `in_ready = (state == IDLE) && (!out_valid || out_ready)`. It is combinational and never depends on `in_valid`.
- Code map (result / branch_taken):
  - 0: 0 / 0, no-op, not illegal.
  - 1: low XLEN bits of `op_a * op_b` (unsigned) / 0.
  - 2: `op_a + op_b`, modulo 2^XLEN / 0.
  - 3: `op_a << op_b[log2(XLEN)-1:0]` / 0.
  - 4: `op_a ^ op_b` / 0.
  - 5: `op_a - op_b` / (`op_a == op_b`).
  - 6: `op_a - op_b`, modulo 2^XLEN / 0.
  - 7: `op_a - op_b` / (signed `op_a >= op_b`).
  - 8–15: 0 / 0, `illegal` = 1.
- FSM has two states: IDLE and MUL.
  - IDLE → MUL on accept of code 1.
  - Every other code loads the output register directly at accept and stays in IDLE.
- MUL state:
  - Holds multiplicand, multiplier, accumulator and a count register sized for XLEN iterations.
  - Each cycle: if multiplier bit 0 is set, add the multiplicand to the accumulator; then shift the multiplicand left and the multiplier right.
  - On the final iteration, load the accumulator result into the output register, set `out_valid`, and go to IDLE.
- Output register:
  - `out_valid` clears on `out_valid && out_ready` unless a new result loads at the same edge. A load wins.
  - While `out_valid && !out_ready`, `result`, `branch_taken` and `illegal` hold stable.
  - `in_ready` is 0 in that case, so no overwrite is possible.

## Timing
- Reset values: `out_valid`=0, `result`=0, `branch_taken`=0, `illegal`=0, state=IDLE, count=0. `in_ready` is 1 after reset.
- Non-multiply latency: accept at edge t → `out_valid`=1 after edge t. Back-to-back accepts every cycle are allowed when `out_ready`=1.
- Multiply latency: accept at edge t → `out_valid`=1 after edge t+XLEN. `in_ready`=0 throughout MUL.
- Simultaneous consume and accept at one edge: the old result retires and the new one is visible after that edge, with no bubble.
- Reset asserted mid-multiply: aborts immediately. No result is produced and all outputs return to their reset values.
- `out_ready` is ignored while `out_valid`=0.

## Configuration
- `ALU_MUL_EN` defined: code 1 uses the iterative multiplier as above.
- `ALU_MUL_EN` undefined:
  - MUL state and multiplier datapath are removed.
  - Code 1 completes in one cycle with `result`=0, `branch_taken`=0, `illegal`=1.
  - `in_ready` reduces to `!out_valid || out_ready`.

## Test plan
- Reset: assert `rst` mid-stream. Required: all outputs 0 asynchronously, `in_ready`=1 after deassert.
- ADD/XOR/SUB back-to-back with `out_ready`=1, XLEN=32:
  - code 2, `op_a`=0xFFFFFFFF, `op_b`=1 → `result` 0x00000000.
  - code 4, 0xF0F0F0F0 ^ 0xFF00FF00 → 0x0FF00FF0.
  - code 6, 5 − 7 → 0xFFFFFFFE.
  - Each result one cycle after its accept, with no bubbles.
- Branches:
  - code 5, 9/9 → `branch_taken`=1.
  - code 7, `op_a`=0xFFFFFFFF, `op_b`=1 → `branch_taken`=0 (signed −1 < 1).
  - code 7, 3/3 → `branch_taken`=1.
- Shift: code 3, `op_a`=1, `op_b`=0x00000025 → `result` 0x00000020 (only the low 5 bits are used).
- Multiply (`ALU_MUL_EN`):
  - code 1, 0x00012345 × 0x00000100 → 0x01234500, with `out_valid` exactly 32 cycles after accept and `in_ready`=0 meanwhile.
  - 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001.
  - Reset at cycle 10 of a multiply → no `out_valid`.
- Backpressure/illegal:
  - Hold `out_ready`=0 after code 2 → `result` stable and `in_ready`=0 for 5 cycles.
  - Code 9 → `illegal`=1, `result`=0.
  - Without `ALU_MUL_EN`, code 1 → `illegal`=1 after one cycle.
